mig1_fetch: RTL

MIG1_FETCH -- requirements
Module: mig1_fetch

---
 rtl/mig1_pkg.sv | 5 +
 rtl/mig1_fetch_fifo.sv | 43 ++++
 rtl/mig1_fetch.sv | 59 +++++
 3 files changed

// File: rtl/mig1_pkg.sv
// mig1_pkg: shared Mig1 fetch-stage types and constants
package mig1_pkg;
    localparam int INST_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/mig1_fetch_fifo.sv
// mig1_fetch_fifo: instruction buffer holding {pc,data} entries
// Ports: clk, reset (async active-low), clr (sync empty), wr_en/wr_data push,
//        rd_en pop, rd_data head entry, count occupancy.
module mig1_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_rd, do_wr;
    assign do_rd   = rd_en && count != '0;
    // a pop in the same cycle frees the slot, so a full buffer still accepts a push
    assign do_wr   = wr_en && (count != CW'(DEPTH) || do_rd);
    assign rd_data = mem[rp];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) mem[wp] <= wr_data;
            wp    <= do_wr ? wp + PW'(1) : wp;
            rp    <= do_rd ? rp + PW'(1) : rp;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/mig1_fetch.sv
// mig1_fetch: Mig1 instruction fetch stage with synchronous-ROM interface and instruction buffer
// Ports: clk, reset (async active-low); imem_addr/imem_data ROM port;
//        redirect_valid/redirect_pc branch redirect; inst_valid/inst_ready/inst_data/inst_pc to decode.
module mig1_fetch
    import mig1_pkg::*;
#(
    parameter int                         IMEM_ADDR_WIDTH = 8,
    parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                         FIFO_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_W-1:0]          imem_data,
    input  logic                       redirect_valid,
    input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_W-1:0]          inst_data,
    output logic [IMEM_ADDR_WIDTH-1:0] inst_pc
);
    localparam int AW = IMEM_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    fetch_state_t  state;
    logic [AW-1:0] fetch_pc, addr_q;
    logic          pending, hs, issue;
    logic [CW-1:0] occ;
    assign inst_valid = occ != '0;
    assign hs         = inst_valid && inst_ready;
    // occupancy is counted net of this cycle's pop so a 1-deep steady stream never stalls
    assign issue      = state == RUN && !redirect_valid &&
                        (int'(occ) - int'(hs) + int'(pending) < FIFO_DEPTH);
    assign imem_addr  = issue ? fetch_pc : addr_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            state    <= redirect_valid ? FLUSH : RUN;
            fetch_pc <= redirect_valid ? {redirect_pc[AW-1:2], 2'b00} :
                        issue ? fetch_pc + AW'(4) : fetch_pc;
            addr_q   <= issue ? fetch_pc : addr_q;
            pending  <= issue;
        end
    end
    // addr_q still holds the address whose ROM data arrives this cycle
    mig1_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(AW + INST_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (redirect_valid),
        .wr_en   (pending),
        .wr_data ({addr_q, imem_data}),
        .rd_en   (hs),
        .rd_data ({inst_pc, inst_data}),
        .count   (occ)
    );
endmodule
